// File: rtl/im_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
package im_arb_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CPU  = 2'd1,
    SRC_LD   = 2'd2,
    SRC_DBG  = 2'd3
  } req_src_t;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_CPU = 0;
  localparam int GNT_LD  = 1;
  localparam int GNT_DBG = 2;

  localparam int          DEPTH_DEF     = 8192;
  localparam logic [16:0] NOP_INSTR_DEF = 17'h00000;

endpackage

// File: rtl/im_arb_grant.sv
// Combinational priority arbiter: loader/debug in BOOT, CPU/debug with a
// starvation override in RUN. Produces a one-hot grant.
module im_arb_grant
  import im_arb_pkg::*;
(
  input  logic       i_en,
  input  logic       i_run,
  input  logic       i_cpu_req,
  input  logic       i_ld_req,
  input  logic       i_dbg_req,
  input  logic       i_cnt_max,
  output logic [2:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      if (!i_run) begin
        if (i_ld_req)       o_gnt[GNT_LD]  = 1'b1;
        else if (i_dbg_req) o_gnt[GNT_DBG] = 1'b1;
      end else begin
        // A debug read that has waited MAX_WAIT cycles pre-empts the CPU once
        if (i_dbg_req && i_cnt_max) o_gnt[GNT_DBG] = 1'b1;
        else if (i_cpu_req)         o_gnt[GNT_CPU] = 1'b1;
        else if (i_dbg_req)         o_gnt[GNT_DBG] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/im_port_arb.sv
// Single-port instruction memory arbiter: BOOT/RUN mode register, debug
// starvation counter, read-return tag and response steering.
module im_port_arb
  import im_arb_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 17,
  parameter int                DEPTH     = DEPTH_DEF,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF),
  parameter int                MAX_WAIT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_stall,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_instr,
  input  logic              ld_wr_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              ld_err,
  input  logic              ld_done,
  input  logic              dbg_rd_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  mode_t             r_mode;
  mode_t             w_mode_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        w_gnt;
  logic              w_gnt_cpu;
  logic              w_gnt_ld;
  logic              w_gnt_dbg;
  logic              w_cpu_in;
  logic              w_ld_in;
  logic              w_dbg_in;
  logic              w_cnt_max;
  req_src_t          r_tag_src_p1;
  logic              r_tag_oor_p1;
  logic [DATA_W-1:0] w_rsp_data_p1;

  assign w_cpu_in  = in_range(cpu_addr);
  assign w_ld_in   = in_range(ld_addr);
  assign w_dbg_in  = in_range(dbg_addr);
  assign w_cnt_max = (r_cnt == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (!rst_n) r_mode <= BOOT;
    else        r_mode <= w_mode_nxt;
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (ld_done) w_mode_nxt = RUN;
  end

  // Reset masks every grant so the memory sees no strobes while rst_n is low
  im_arb_grant u_grant (
    .i_en      (rst_n),
    .i_run     (r_mode == RUN),
    .i_cpu_req (cpu_rd_req),
    .i_ld_req  (ld_wr_req),
    .i_dbg_req (dbg_rd_req),
    .i_cnt_max (w_cnt_max),
    .o_gnt     (w_gnt)
  );

  assign w_gnt_cpu = w_gnt[GNT_CPU];
  assign w_gnt_ld  = w_gnt[GNT_LD];
  assign w_gnt_dbg = w_gnt[GNT_DBG];

  assign cpu_stall = cpu_rd_req & ~w_gnt_cpu;
  assign ld_ack    = w_gnt_ld;
  assign ld_err    = rst_n & (r_mode == RUN) & ld_wr_req;

  always_comb begin
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    if (w_gnt_cpu) begin
      mem_addr  = cpu_addr;
      mem_rd_en = w_cpu_in;
    end else if (w_gnt_dbg) begin
      mem_addr  = dbg_addr;
      mem_rd_en = w_dbg_in;
    end else if (w_gnt_ld) begin
      mem_addr  = ld_addr;
      mem_wr_en = w_ld_in;
      mem_wdata = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_gnt_dbg)
      r_cnt <= '0;
    else if ((r_mode == RUN) && dbg_rd_req && !w_cnt_max)
      r_cnt <= r_cnt + 1'b1;
  end

  // ---- p0 -> p1: grant cycle to read-return cycle ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_src_p1 <= SRC_NONE;
      r_tag_oor_p1 <= 1'b0;
    end else if (w_gnt_cpu) begin
      r_tag_src_p1 <= SRC_CPU;
      r_tag_oor_p1 <= ~w_cpu_in;
    end else if (w_gnt_dbg) begin
      r_tag_src_p1 <= SRC_DBG;
      r_tag_oor_p1 <= ~w_dbg_in;
    end else begin
      r_tag_src_p1 <= SRC_NONE;
      r_tag_oor_p1 <= 1'b0;
    end
  end

  assign w_rsp_data_p1 = r_tag_oor_p1 ? NOP_INSTR : mem_rdata;

  // Gating with rst_n drops a read that was in flight when reset arrived
  assign cpu_valid = rst_n & (r_tag_src_p1 == SRC_CPU);
  assign dbg_valid = rst_n & (r_tag_src_p1 == SRC_DBG);
  assign cpu_instr = cpu_valid ? w_rsp_data_p1 : '0;
  assign dbg_rdata = dbg_valid ? w_rsp_data_p1 : '0;

endmodule

// File: tb/tb_im_port_arb.sv
// Directed bench for im_port_arb with a simple one-cycle-latency memory model.
module tb_im_port_arb;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 17;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_rd_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_stall;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_instr;
  logic              ld_wr_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic              ld_err;
  logic              ld_done;
  logic              dbg_rd_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_valid;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] tmem [0:8191];

  int checks = 0;
  int errors = 0;

  im_port_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_rd_req (cpu_rd_req),
    .cpu_addr   (cpu_addr),
    .cpu_stall  (cpu_stall),
    .cpu_valid  (cpu_valid),
    .cpu_instr  (cpu_instr),
    .ld_wr_req  (ld_wr_req),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .ld_ack     (ld_ack),
    .ld_err     (ld_err),
    .ld_done    (ld_done),
    .dbg_rd_req (dbg_rd_req),
    .dbg_addr   (dbg_addr),
    .dbg_valid  (dbg_valid),
    .dbg_rdata  (dbg_rdata),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) tmem[mem_addr[12:0]] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= tmem[mem_addr[12:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cpu_rd_req = 1'b1; cpu_addr = '0;
    ld_wr_req = 1'b1; ld_addr = '0; ld_data = 17'h1ABCD; ld_done = 1'b0;
    dbg_rd_req = 1'b0; dbg_addr = '0;
    tick(); #1;
    chk("rst_cpu_stall", cpu_stall, 1);
    chk("rst_ld_ack", ld_ack, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_cpu_valid", cpu_valid, 0);
    chk("rst_dbg_valid", dbg_valid, 0);
    chk("rst_cpu_instr", cpu_instr, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_ld_err", ld_err, 0);
    tick();

    // BOOT: write 0x0000 <- 1ABCD with CPU requesting
    rst_n = 1'b1; #1;
    chk("boot_w0_ack", ld_ack, 1);
    chk("boot_w0_wr_en", mem_wr_en, 1);
    chk("boot_w0_addr", mem_addr, 16'h0000);
    chk("boot_w0_wdata", mem_wdata, 17'h1ABCD);
    chk("boot_w0_stall", cpu_stall, 1);
    chk("boot_w0_rd_en", mem_rd_en, 0);
    chk("boot_w0_ld_err", ld_err, 0);
    tick();

    // BOOT: out-of-range write is acked but not performed
    ld_addr = 16'h2000; ld_data = 17'h1FFFF; #1;
    chk("boot_oor_ack", ld_ack, 1);
    chk("boot_oor_wr_en", mem_wr_en, 0);
    chk("boot_oor_stall", cpu_stall, 1);
    chk("boot_oor_cpu_valid", cpu_valid, 0);
    tick();

    // BOOT: write 0x1FFF <- 00042 in the same cycle as ld_done
    ld_addr = 16'h1FFF; ld_data = 17'h00042; ld_done = 1'b1; #1;
    chk("boot_w1_ack", ld_ack, 1);
    chk("boot_w1_wr_en", mem_wr_en, 1);
    chk("boot_w1_addr", mem_addr, 16'h1FFF);
    chk("boot_w1_wdata", mem_wdata, 17'h00042);
    chk("boot_w1_stall", cpu_stall, 1);
    chk("boot_w1_cpu_valid", cpu_valid, 0);
    tick();

    // RUN: back-to-back CPU reads
    ld_wr_req = 1'b0; ld_done = 1'b0; cpu_addr = 16'h0000; #1;
    chk("run_r0_cpu_valid_prev", cpu_valid, 0);
    chk("run_r0_stall", cpu_stall, 0);
    chk("run_r0_rd_en", mem_rd_en, 1);
    chk("run_r0_addr", mem_addr, 16'h0000);
    tick();
    cpu_addr = 16'h1FFF; #1;
    chk("run_r0_valid", cpu_valid, 1);
    chk("run_r0_instr", cpu_instr, 17'h1ABCD);
    chk("run_r1_stall", cpu_stall, 0);
    chk("run_r1_addr", mem_addr, 16'h1FFF);
    tick();

    // RUN: debug starvation guard, twice to show the counter restarts at 0
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 1; i <= 9; i++) begin
        dbg_rd_req = 1'b1;
        dbg_addr = (rep == 0) ? 16'h0000 : 16'h1FFF;
        #1;
        chk("starve_cpu_valid", cpu_valid, 1);
        chk("starve_cpu_instr", cpu_instr, 17'h00042);
        chk("starve_cpu_stall", cpu_stall, (i == 9) ? 1 : 0);
        chk("starve_dbg_valid", dbg_valid, 0);
        tick();
      end
      dbg_rd_req = 1'b0; #1;
      chk("starve_dbg_valid_ret", dbg_valid, 1);
      chk("starve_dbg_rdata", dbg_rdata, (rep == 0) ? 17'h1ABCD : 17'h00042);
      chk("starve_cpu_valid_gap", cpu_valid, 0);
      chk("starve_cpu_stall_after", cpu_stall, 0);
      tick();
    end

    // RUN: loader writes are rejected
    cpu_rd_req = 1'b0; ld_wr_req = 1'b1; ld_addr = 16'h0000; ld_data = 17'h00777;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("run_ld_err", ld_err, 1);
      chk("run_ld_ack", ld_ack, 0);
      chk("run_ld_wr_en", mem_wr_en, 0);
      tick();
    end
    ld_wr_req = 1'b0; dbg_rd_req = 1'b1; dbg_addr = 16'h0000; #1;
    chk("run_ld_err_off", ld_err, 0);
    chk("readback_rd_en", mem_rd_en, 1);
    chk("readback_addr", mem_addr, 16'h0000);
    tick();
    dbg_rd_req = 1'b0; #1;
    chk("readback_valid", dbg_valid, 1);
    chk("readback_data", dbg_rdata, 17'h1ABCD);
    tick();

    // RUN: out-of-range reads return NOP without touching memory
    cpu_rd_req = 1'b1; cpu_addr = 16'h2000; dbg_rd_req = 1'b1; dbg_addr = 16'hFFFF; #1;
    chk("oor_cpu_rd_en", mem_rd_en, 0);
    chk("oor_cpu_stall", cpu_stall, 0);
    chk("oor_dbg_valid_early", dbg_valid, 0);
    tick();
    cpu_rd_req = 1'b0; #1;
    chk("oor_cpu_valid", cpu_valid, 1);
    chk("oor_cpu_instr", cpu_instr, 17'h00000);
    chk("oor_dbg_rd_en", mem_rd_en, 0);
    chk("oor_dbg_addr", mem_addr, 16'hFFFF);
    tick();
    dbg_rd_req = 1'b0; #1;
    chk("oor_dbg_valid", dbg_valid, 1);
    chk("oor_dbg_rdata", dbg_rdata, 17'h00000);
    chk("oor_cpu_valid_off", cpu_valid, 0);
    chk("idle_mem_addr", mem_addr, 16'h0000);
    chk("idle_rd_en", mem_rd_en, 0);
    tick();

    // Reset while a CPU read is in flight
    cpu_rd_req = 1'b1; cpu_addr = 16'h0000; #1;
    chk("midrst_grant_stall", cpu_stall, 0);
    chk("midrst_grant_rd_en", mem_rd_en, 1);
    tick();
    rst_n = 1'b0; #1;
    chk("midrst_cpu_valid", cpu_valid, 0);
    chk("midrst_cpu_instr", cpu_instr, 0);
    chk("midrst_stall", cpu_stall, 1);
    tick();
    rst_n = 1'b1; dbg_rd_req = 1'b1; dbg_addr = 16'h1FFF; #1;
    chk("postrst_cpu_valid", cpu_valid, 0);
    chk("postrst_boot_stall", cpu_stall, 1);
    chk("postrst_dbg_rd_en", mem_rd_en, 1);
    chk("postrst_dbg_addr", mem_addr, 16'h1FFF);
    tick();
    dbg_rd_req = 1'b0; #1;
    chk("postrst_dbg_valid", dbg_valid, 1);
    chk("postrst_dbg_rdata", dbg_rdata, 17'h00042);
    chk("postrst_cpu_valid2", cpu_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
